// File: rtl/pipe_data_path.sv
// Two-stage execute/writeback integer datapath: register file, 8-op ALU,
// immediate mux and a single WB register with forwarding into execute.
module pipe_data_path #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int A0_INDEX      = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     RegWrite,
  input  logic                     ALUsrc,
  input  logic [2:0]               ALUctrl,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     EQ,
  output logic                     LT,
  output logic                     wb_valid,
  output logic [ADDRESS_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_data,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam int SHW  = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_XOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;

  typedef struct packed {
    logic                     vld;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]    data;
  } wb_t;

  wb_t                               wb_q;
  logic [NREG-1:0][DATA_WIDTH-1:0]   regs;
  logic                              issue, commit;
  logic [DATA_WIDTH-1:0]             rv1, rv2, op1, op2, alu_res;

  assign issue  = in_valid & ~stall;
  assign commit = wb_q.vld & wb_q.we & (wb_q.rd != '0);

  // x0 is hardwired; entries 1..NREG-1 take the committing WB value.
  assign regs[0] = '0;
  for (genvar r = 1; r < NREG; r++) begin : g_rf
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                regs[r] <= '0;
      else if (commit && wb_q.rd == ADDRESS_WIDTH'(r))        regs[r] <= wb_q.data;
    end
  end

  // Forwarding: a pending WB result overrides the stale register file read.
  always_comb begin
    rv1 = regs[rs1];
    rv2 = regs[rs2];
    if (commit && wb_q.rd == rs1) rv1 = wb_q.data;
    if (commit && wb_q.rd == rs2) rv2 = wb_q.data;
  end

  assign op1 = rv1;
  assign op2 = ALUsrc ? ImmOp : rv2;
  assign EQ  = (rv1 == rv2);
  assign LT  = ($signed(rv1) < $signed(rv2));

  always_comb begin
    alu_res = '0;
    case (ALUctrl)
      OP_ADD: alu_res = op1 + op2;
      OP_SUB: alu_res = op1 - op2;
      OP_AND: alu_res = op1 & op2;
      OP_OR:  alu_res = op1 | op2;
      OP_XOR: alu_res = op1 ^ op2;
      OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLL: alu_res = op1 << op2[SHW-1:0];
      OP_SRL: alu_res = op1 >> op2[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // A stalled or idle cycle leaves a bubble but keeps the last rd/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q.vld <= issue;
      wb_q.we  <= RegWrite;
      if (issue) begin
        wb_q.rd   <= rd;
        wb_q.data <= alu_res;
      end
    end
  end

  assign wb_valid = wb_q.vld;
  assign wb_rd    = wb_q.rd;
  assign wb_data  = wb_q.data;
  assign a0       = regs[A0_INDEX];

endmodule

// File: doc/pipe_data_path.md
Name: pipe_data_path

Overview:
Two-stage (execute / writeback) integer datapath: the next generation of the single-cycle RISC-V data path. It bundles a parametrised register file, an 8-operation ALU, an immediate mux and one writeback pipeline register with full forwarding. It sits between the control unit and the PC/branch logic. It exposes EQ/LT branch flags and the a0 debug register.

Parameters:
DATA_WIDTH, 32, datapath and register width (>=8, power of 2)
ADDRESS_WIDTH, 5, register index width; the register file holds 2**ADDRESS_WIDTH entries
A0_INDEX, 10, register index mirrored on the a0 output

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  an instruction is presented this cycle
stall  input  1  hold: suppress issue this cycle
RegWrite  input  1  instruction writes rd
ALUsrc  input  1  0 = ALU op2 is rs2 value, 1 = ALU op2 is ImmOp
ALUctrl  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL
rs1, rs2, rd  input  ADDRESS_WIDTH each  register indices
ImmOp  input  DATA_WIDTH  sign-extended immediate
EQ  output  1  forwarded rs1 value == forwarded rs2 value (combinational)
LT  output  1  forwarded rs1 value < forwarded rs2 value, signed (combinational)
wb_valid  output  1  writeback stage holds a valid instruction
wb_rd  output  ADDRESS_WIDTH  writeback destination index
wb_data  output  DATA_WIDTH  writeback ALU result
a0  output  DATA_WIDTH  current contents of register A0_INDEX

Behaviour:
- Issue condition: issue = in_valid & ~stall.
- Execute stage (combinational, cycle N):
  - Read rs1 and rs2 from the register file.
  - Forward from the WB register: if wb_valid & wb_we & wb_rd == rsX & rsX != 0, use wb_data instead of the register file value.
  - Index 0 always reads 0, forwarding included.
- Operand selection: op1 = forwarded rs1 value; op2 = ALUsrc ? ImmOp : forwarded rs2 value.
- EQ and LT always compare the two forwarded register values; ImmOp is never used for them. They are valid in the same cycle regardless of in_valid.
- ALU arithmetic and width rules:
  - ADD/SUB wrap modulo 2**DATA_WIDTH; no carry out.
  - SLT yields 1 or 0, zero-extended.
  - SLL/SRL shift by op2[$clog2(DATA_WIDTH)-1:0]; upper bits of op2 are ignored; SRL is logical.
- At posedge, the WB register loads:
  - wb_valid <= issue
  - wb_we <= RegWrite
  - wb_rd <= rd
  - wb_data <= ALU result
  - wb_rd and wb_data update only when issue=1; otherwise they hold.
- Writeback, at the next posedge (cycle N+1 end): if wb_valid & wb_we & wb_rd != 0, the register file entry wb_rd <= wb_data.
  - Writes to x0 are discarded.
- Result latency: 1 cycle to wb_data; the architectural register is updated 2 edges after issue. Forwarding makes back-to-back dependent instructions correct with no bubble.
- Simultaneous events:
  - The register file write and the WB register load occur on the same edge. The instruction reading in that cycle sees the WB value through forwarding.
  - A stalled cycle injects a bubble (wb_valid=0). The previous WB still commits on that edge.
- a0 reflects the register file entry A0_INDEX. It is a committed value, not forwarded.
- Reset (asynchronous, any time, including mid-stream):
  - All registers clear to 0: wb_valid=0, wb_rd=0, wb_data=0.
  - An in-flight WB instruction is dropped, not committed.
  - After reset: a0=0, EQ=1 (0==0), LT=0.
  - The first edge after rst deasserts behaves normally.

Test Plan:
- Reset -> a0=0, wb_valid=0, wb_data=0; with rs1=rs2=3, EQ=1 and LT=0.
- Issue ADD x1=x0+imm 5 (ALUsrc=1), then ADD x2=x1+imm 7 next cycle -> wb_data 5 then 12; after 2 more edges x2=12, no bubble needed.
- Issue ADD x10=x0+imm -1 -> a0 stays 0 for 1 edge, then a0=0xFFFFFFFF; next SLT x3=x10,x0 -> wb_data=1, and LT=1 while rs1=10, rs2=0.
- ADD x0=x0+imm 9, then read rs1=0 -> op1=0, no forwarding, x0 remains 0.
- Issue with stall=1 during a dependent pair -> wb_valid=0 that cycle, wb_data holds; the prior result commits; resumption forwards correctly. SLL by imm 33 with DATA_WIDTH=32 -> shift by 1.
- Assert rst while wb_valid=1 writing x5=0xAA -> x5 stays 0, all outputs return to reset values immediately (asynchronously).
